// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings, direction and default speed limits.
// The LED_PINGPONG_EN macro decides whether mode 11 decodes as PINGPONG or falls back to FLASH.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_FLASH    = 2'b00,
        MODE_SHIFT_L  = 2'b01,
        MODE_SHIFT_R  = 2'b10,
        MODE_PINGPONG = 2'b11
    } led_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int unsigned DEF_LIMIT_R0 = 32'd33554431;
    localparam int unsigned DEF_LIMIT_R1 = 32'd16777215;
    localparam int unsigned DEF_LIMIT_R2 = 32'd8388607;
    localparam int unsigned DEF_LIMIT_R3 = 32'd4194303;

    // Without ping-pong support, mode 11 is indistinguishable from FLASH, including mode-change detection.
    function automatic led_mode_e decode_mode(input logic [1:0] raw);
`ifdef LED_PINGPONG_EN
        return led_mode_e'(raw);
`else
        return (raw == 2'b11) ? MODE_FLASH : led_mode_e'(raw);
`endif
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts enabled cycles and raises a step strobe when the count reaches the selected limit.
// The strobe is combinational so the parent can update its pattern and registered tick on the same edge.
module led_tick_gen #(
    parameter int NB_COUNT = 32
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_clear,
    input  logic [NB_COUNT-1:0] i_limit,
    output logic                o_tick
);

    logic [NB_COUNT-1:0] count;

    // Using >= lets a drop to a faster speed fire immediately when the count is already past the new limit.
    assign o_tick = i_enable && !i_clear && (count >= i_limit);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            if (o_tick) begin
                count <= '0;
            end else begin
                count <= count + NB_COUNT'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: FLASH, rotate left/right and (with LED_PINGPONG_EN) a bouncing single lit LED.
// A change of i_mode reloads the pattern and restarts the prescaler, whatever i_enable is doing.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int          NB_LEDS  = 4,
    parameter int          NB_COUNT = 32,
    parameter int unsigned LIMIT_R0 = DEF_LIMIT_R0,
    parameter int unsigned LIMIT_R1 = DEF_LIMIT_R1,
    parameter int unsigned LIMIT_R2 = DEF_LIMIT_R2,
    parameter int unsigned LIMIT_R3 = DEF_LIMIT_R3
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_speed,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_tick
);

    localparam logic [NB_LEDS-1:0] LED_LSB = NB_LEDS'(1);
    localparam logic [NB_LEDS-1:0] LED_MSB = LED_LSB << (NB_LEDS - 1);

    led_mode_e           mode_q;
    led_mode_e           mode_in;
    logic                mode_change;
    logic                step;
    logic [NB_COUNT-1:0] limit;
    logic [NB_LEDS-1:0]  rot_l;
    logic [NB_LEDS-1:0]  rot_r;
    logic [NB_LEDS-1:0]  led_next;
    logic [NB_LEDS-1:0]  led_reload;
`ifdef LED_PINGPONG_EN
    dir_e                dir_q;
    dir_e                dir_next;
`endif

    assign mode_in     = decode_mode(i_mode);
    assign mode_change = (mode_in != mode_q);

    always_comb begin
        case (i_speed)
            2'd0:    limit = NB_COUNT'(LIMIT_R0);
            2'd1:    limit = NB_COUNT'(LIMIT_R1);
            2'd2:    limit = NB_COUNT'(LIMIT_R2);
            default: limit = NB_COUNT'(LIMIT_R3);
        endcase
    end

    led_tick_gen #(
        .NB_COUNT (NB_COUNT)
    ) u_tick_gen (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_clear  (mode_change),
        .i_limit  (limit),
        .o_tick   (step)
    );

    // A single LED has nowhere to rotate to, so both rotations degenerate to a hold.
    generate
        if (NB_LEDS == 1) begin : g_single
            assign rot_l = o_led;
            assign rot_r = o_led;
        end else begin : g_multi
            assign rot_l = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
            assign rot_r = {o_led[0], o_led[NB_LEDS-1:1]};
        end
    endgenerate

    always_comb begin
        case (mode_in)
            MODE_SHIFT_L:  led_reload = LED_LSB;
            MODE_SHIFT_R:  led_reload = LED_MSB;
`ifdef LED_PINGPONG_EN
            MODE_PINGPONG: led_reload = LED_LSB;
`endif
            default:       led_reload = '1;
        endcase
    end

    always_comb begin
        led_next = o_led;
`ifdef LED_PINGPONG_EN
        dir_next = dir_q;
`endif
        case (mode_q)
            MODE_SHIFT_L: led_next = rot_l;
            MODE_SHIFT_R: led_next = rot_r;
`ifdef LED_PINGPONG_EN
            // Bounce off either end: the step that leaves an end bit also reverses direction.
            MODE_PINGPONG: begin
                if (NB_LEDS > 1) begin
                    if (dir_q == DIR_LEFT) begin
                        if (o_led[NB_LEDS-1]) begin
                            led_next = o_led >> 1;
                            dir_next = DIR_RIGHT;
                        end else begin
                            led_next = o_led << 1;
                        end
                    end else begin
                        if (o_led[0]) begin
                            led_next = o_led << 1;
                            dir_next = DIR_LEFT;
                        end else begin
                            led_next = o_led >> 1;
                        end
                    end
                end
            end
`endif
            default: led_next = ~o_led;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_led  <= '1;
            o_tick <= 1'b0;
            mode_q <= MODE_FLASH;
        end else if (mode_change) begin
            o_led  <= led_reload;
            o_tick <= 1'b0;
            mode_q <= mode_in;
        end else begin
            o_tick <= step;
            if (step) begin
                o_led <= led_next;
            end
        end
    end

`ifdef LED_PINGPONG_EN
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            dir_q <= DIR_LEFT;
        end else if (mode_change) begin
            dir_q <= DIR_LEFT;
        end else if (step) begin
            dir_q <= dir_next;
        end
    end
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with 4 LEDs and short limits (3, 7, 15, 31).
// Expected ping-pong values follow the LED_PINGPONG_EN setting of the build.
module tb_led_pattern_gen;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_mode;
    logic [1:0] i_speed;
    logic [3:0] o_led;
    logic       o_tick;

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clock = ~clock;

    led_pattern_gen #(
        .NB_LEDS  (4),
        .NB_COUNT (8),
        .LIMIT_R0 (3),
        .LIMIT_R1 (7),
        .LIMIT_R2 (15),
        .LIMIT_R3 (31)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_mode   (i_mode),
        .i_speed  (i_speed),
        .o_led    (o_led),
        .o_tick   (o_tick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enable, input logic [1:0] mode, input logic [1:0] speed);
        i_enable = enable;
        i_mode   = mode;
        i_speed  = speed;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Returns the number of cycles until o_tick is seen, or -1 if the budget runs out.
    task automatic waitTick(input int budget, output int cycles);
        cycles = 0;
        do begin
            stepCycle();
            cycles++;
        end while (o_tick !== 1'b1 && cycles < budget);
        if (o_tick !== 1'b1) cycles = -1;
    endtask

    task automatic countTicks(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            stepCycle();
            if (o_tick === 1'b1) ticks++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         cycles;
        int         ticks;
        logic [3:0] flash_seq [3];
        logic [3:0] shl_seq   [4];
        logic [3:0] shr_seq   [4];
        logic [3:0] pp_seq    [6];
        logic [3:0] pp_reload;
        logic [3:0] speed_led0;
        logic [3:0] speed_led1;
        logic [3:0] freeze_led;

        flash_seq = '{4'b0000, 4'b1111, 4'b0000};
        shl_seq   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        shr_seq   = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
`ifdef LED_PINGPONG_EN
        pp_reload  = 4'b0001;
        pp_seq     = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        speed_led0 = 4'b0010;
        speed_led1 = 4'b0100;
        freeze_led = 4'b1000;
`else
        pp_reload  = 4'b1111;
        pp_seq     = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
        speed_led0 = 4'b0000;
        speed_led1 = 4'b1111;
        freeze_led = 4'b0000;
`endif

        applyStimulus(1'b0, 2'b00, 2'd0);
        i_reset = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_led", 32'(o_led), 32'hF);
        checkOutput("reset_tick", 32'(o_tick), 32'h0);

        i_reset = 1'b1;
        countTicks(20, ticks);
        checkOutput("idle_ticks", 32'(ticks), 32'd0);
        checkOutput("idle_led", 32'(o_led), 32'hF);

        applyStimulus(1'b1, 2'b00, 2'd0);
        for (int i = 0; i < 3; i++) begin
            waitTick(50, cycles);
            checkOutput("flash_period", 32'(cycles), 32'd4);
            checkOutput("flash_led", 32'(o_led), 32'(flash_seq[i]));
        end

        applyStimulus(1'b1, 2'b01, 2'd0);
        stepCycle();
        checkOutput("shl_reload_led", 32'(o_led), 32'h1);
        checkOutput("shl_reload_tick", 32'(o_tick), 32'h0);
        for (int i = 0; i < 4; i++) begin
            waitTick(50, cycles);
            checkOutput("shl_period", 32'(cycles), 32'd4);
            checkOutput("shl_led", 32'(o_led), 32'(shl_seq[i]));
        end

        applyStimulus(1'b1, 2'b10, 2'd0);
        stepCycle();
        checkOutput("shr_reload_led", 32'(o_led), 32'h8);
        for (int i = 0; i < 4; i++) begin
            waitTick(50, cycles);
            checkOutput("shr_period", 32'(cycles), 32'd4);
            checkOutput("shr_led", 32'(o_led), 32'(shr_seq[i]));
        end

        applyStimulus(1'b1, 2'b11, 2'd0);
        stepCycle();
        checkOutput("pp_reload_led", 32'(o_led), 32'(pp_reload));
        for (int i = 0; i < 6; i++) begin
            waitTick(50, cycles);
            checkOutput("pp_period", 32'(cycles), 32'd4);
            checkOutput("pp_led", 32'(o_led), 32'(pp_seq[i]));
        end

        // Count up to 5 on the slow limit, then drop to the fast limit which is already exceeded.
        applyStimulus(1'b1, 2'b11, 2'd1);
        countTicks(5, ticks);
        checkOutput("slow_no_tick", 32'(ticks), 32'd0);
        applyStimulus(1'b1, 2'b11, 2'd0);
        stepCycle();
        checkOutput("speed_drop_tick", 32'(o_tick), 32'h1);
        checkOutput("speed_drop_led", 32'(o_led), 32'(speed_led0));
        waitTick(50, cycles);
        checkOutput("speed_drop_period", 32'(cycles), 32'd4);
        checkOutput("speed_drop_led2", 32'(o_led), 32'(speed_led1));

        countTicks(2, ticks);
        checkOutput("pre_freeze_ticks", 32'(ticks), 32'd0);
        applyStimulus(1'b0, 2'b11, 2'd0);
        countTicks(10, ticks);
        checkOutput("freeze_ticks", 32'(ticks), 32'd0);
        checkOutput("freeze_led", 32'(o_led), 32'(speed_led1));
        applyStimulus(1'b1, 2'b11, 2'd0);
        waitTick(50, cycles);
        checkOutput("resume_period", 32'(cycles), 32'd2);
        checkOutput("resume_led", 32'(o_led), 32'(freeze_led));

        stepCycle();
        stepCycle();
        i_reset = 1'b0;
        #2;
        checkOutput("async_reset_led", 32'(o_led), 32'hF);
        checkOutput("async_reset_tick", 32'(o_tick), 32'h0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 2'b00, 2'd0);
        i_reset = 1'b1;
        waitTick(50, cycles);
        checkOutput("restart_period", 32'(cycles), 32'd4);
        checkOutput("restart_led", 32'(o_led), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter NB_LEDS, default 4, giving the LED vector width; legal values are 1 or more.
REQ-002 The block SHALL have parameter NB_COUNT, default 32, giving the prescaler counter width.
REQ-003 The block SHALL have parameters LIMIT_R0, LIMIT_R1, LIMIT_R2, LIMIT_R3, defaults 2**25-1, 2**24-1, 2**23-1, 2**22-1, giving the terminal count per speed setting.
REQ-004 clock: input, 1 bit, single clock, rising edge.
REQ-005 i_reset: input, 1 bit, reset that is asynchronous and active-low.
REQ-006 i_enable: input, 1 bit; 1 = advance, 0 = freeze.
REQ-007 i_mode: input, 2 bits; 00 FLASH, 01 SHIFT_L, 10 SHIFT_R, 11 PINGPONG.
REQ-008 i_speed: input, 2 bits; selects LIMIT_R0 to LIMIT_R3.
REQ-009 o_led: output, NB_LEDS bits, registered pattern.
REQ-010 o_tick: output, 1 bit, registered one-cycle pulse marking each pattern step.

Function
REQ-011 While i_enable=1, the prescaler SHALL increment by 1 per cycle.
REQ-012 When i_enable=1 and counter >= selected limit, the prescaler SHALL clear to 0, o_led SHALL step, and o_tick SHALL be 1 for that cycle.
REQ-013 The >= rule SHALL cover a speed reduction while the counter is above the new limit.
REQ-014 While i_enable=0, the counter, o_led and direction SHALL hold, and o_tick SHALL be 0.
REQ-015 FLASH step SHALL be o_led <= ~o_led.
REQ-016 SHIFT_L step SHALL rotate left by 1, with MSB wrapping to LSB.
REQ-017 SHIFT_R step SHALL rotate right by 1, with LSB wrapping to MSB.
REQ-018 PINGPONG step SHALL move the single lit bit one place in the current direction.
REQ-019 In PINGPONG, on reaching MSB moving left, the next step SHALL go to bit NB_LEDS-2 and the direction SHALL flip to right; the LSB end SHALL be symmetric.
REQ-020 The registered mode SHALL track i_mode; on any cycle where i_mode differs from it, the pattern SHALL be reloaded, with priority over a tick, regardless of i_enable.
REQ-021 Reload values SHALL be: FLASH all ones; SHIFT_L and PINGPONG 1 at LSB; SHIFT_R 1 at MSB. The counter SHALL go to 0, direction to left, and o_tick to 0.
REQ-022 With NB_LEDS=1, the shift and PINGPONG modes SHALL hold o_led while o_tick still pulses.
REQ-023 Arithmetic SHALL be unsigned on NB_COUNT bits; every limit SHALL be below 2**NB_COUNT.

Reset
REQ-024 While i_reset=0, regardless of clock: o_led all ones, o_tick 0, counter 0, registered mode FLASH, direction left.
REQ-025 Reset asserted mid-count or mid-sweep SHALL abort immediately; after release, operation SHALL restart from the reset state.

Configuration
REQ-026 Macro LED_PINGPONG_EN defined: PINGPONG mode and the direction register SHALL be present.
REQ-027 Macro LED_PINGPONG_EN undefined: i_mode=11 SHALL behave exactly as FLASH, including reload value, and no direction register SHALL exist.

Structure
REQ-028 A shared package led_pkg SHALL hold the mode encodings (MODE_FLASH, MODE_SHIFT_L, MODE_SHIFT_R, MODE_PINGPONG) and the default limit constants.
REQ-029 The prescaler SHALL be a sub-module, led_tick_gen, with inputs clock, i_reset, i_enable, i_clear and i_limit, and output o_tick.

Verification (NB_LEDS=4, LIMIT_R0=3, LIMIT_R1=7)
REQ-030 Reset: hold i_reset=0 -> o_led=1111, o_tick=0; release with i_enable=0 for 20 cycles -> unchanged.
REQ-031 FLASH, i_speed=0, i_enable=1 -> o_tick every 4 cycles; o_led goes 0000, 1111, 0000.
REQ-032 Switch to SHIFT_L -> o_led=0001 next cycle; the following ticks give 0010, 0100, 1000, 0001.
REQ-033 PINGPONG -> 0001, 0010, 0100, 1000, 0100, 0010, 0001; with the macro undefined -> 1111, 0000 toggling.
REQ-034 i_speed=1, counter at 5, switch to i_speed=0 -> tick on the next edge, counter 0, then a period of 4.
REQ-035 i_enable=0 for 10 cycles mid-period -> no tick and o_led frozen; re-enable -> tick after the remaining count only; i_reset=0 mid-sweep -> o_led=1111 asynchronously.
